// File: rtl/sampled_value_checker.sv
// Synthesizable sampled-value monitor: compares signal_in against its value DEPTH clocks earlier.
// Optional match/fail event counters are enabled by defining SVC_EVENT_COUNT_EN.
module sampled_value_checker #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] signal_in,
    output logic             match,
    output logic             fail,
    output logic             ready,
    output logic             fail_sticky
`ifdef SVC_EVENT_COUNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] fail_cnt
`endif
);

    typedef enum logic [1:0] {
        MODE_STABLE  = 2'd0,
        MODE_CHANGED = 2'd1,
        MODE_ROSE    = 2'd2,
        MODE_FELL    = 2'd3
    } mode_e;

    localparam int FW = $clog2(DEPTH + 2);
    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH + 1);

    if (WIDTH < 1) begin : g_bad_width
        $error("sampled_value_checker: WIDTH must be >= 1");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("sampled_value_checker: DEPTH must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("sampled_value_checker: CNT_W must be >= 1");
    end

    logic [WIDTH-1:0] h [0:DEPTH];
    logic             en_q;
    mode_e            mode_q;
    logic [FW-1:0]    fill;
    logic             result;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] past;

    // History shifts every edge regardless of en so warm-up and distance never depend on enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= DEPTH; i++) begin
                h[i] <= '0;
            end
            en_q   <= 1'b0;
            mode_q <= MODE_STABLE;
            fill   <= '0;
        end else begin
            h[0] <= signal_in;
            for (int i = 1; i <= DEPTH; i++) begin
                h[i] <= h[i-1];
            end
            en_q   <= en;
            mode_q <= mode_e'(mode);
            if (fill != FILL_MAX) begin
                fill <= fill + 1'b1;
            end
        end
    end

    assign cur   = h[0];
    assign past  = h[DEPTH];
    assign ready = (fill == FILL_MAX);

    // rose/fell look at bit 0 only, matching the SV $rose/$fell definition.
    always_comb begin
        result = 1'b0;
        case (mode_q)
            MODE_STABLE:  result = (cur == past);
            MODE_CHANGED: result = (cur != past);
            MODE_ROSE:    result = ~past[0] & cur[0];
            MODE_FELL:    result = past[0] & ~cur[0];
            default:      result = 1'b0;
        endcase
    end

    assign match = en_q & ready & result;
    assign fail  = en_q & ready & ~result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_sticky <= 1'b0;
        end else if (clr) begin
            fail_sticky <= 1'b0;
        end else if (fail) begin
            fail_sticky <= 1'b1;
        end
    end

`ifdef SVC_EVENT_COUNT_EN
    // Counters saturate at all-ones; clr beats a same-edge increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt <= '0;
            fail_cnt  <= '0;
        end else if (clr) begin
            match_cnt <= '0;
            fail_cnt  <= '0;
        end else begin
            if (match && (match_cnt != {CNT_W{1'b1}})) begin
                match_cnt <= match_cnt + 1'b1;
            end
            if (fail && (fail_cnt != {CNT_W{1'b1}})) begin
                fail_cnt <= fail_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sampled_value_checker.sv
// Directed bench for sampled_value_checker: three instances (DEPTH 1, 2, 3) share one stimulus.
// Counter checks are compiled in only when SVC_EVENT_COUNT_EN is defined.
module tb_sampled_value_checker;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [1:0] mode;
    logic [7:0] sig;

    logic m1, f1, r1, s1;
    logic m2, f2, r2, s2;
    logic m3, f3, r3, s3;
`ifdef SVC_EVENT_COUNT_EN
    logic [1:0]  mc1, fc1;
    logic [15:0] mc2, fc2, mc3, fc3;
`endif

    int n_cmp;
    int n_err;
    logic [1:0] exp_q[$];

    sampled_value_checker #(.WIDTH(8), .DEPTH(1), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .signal_in(sig),
        .match(m1), .fail(f1), .ready(r1), .fail_sticky(s1)
`ifdef SVC_EVENT_COUNT_EN
        , .match_cnt(mc1), .fail_cnt(fc1)
`endif
    );

    sampled_value_checker #(.WIDTH(8), .DEPTH(2)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .signal_in(sig),
        .match(m2), .fail(f2), .ready(r2), .fail_sticky(s2)
`ifdef SVC_EVENT_COUNT_EN
        , .match_cnt(mc2), .fail_cnt(fc2)
`endif
    );

    sampled_value_checker #(.WIDTH(8), .DEPTH(3)) u3 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .signal_in(sig),
        .match(m3), .fail(f3), .ready(r3), .fail_sticky(s3)
`ifdef SVC_EVENT_COUNT_EN
        , .match_cnt(mc3), .fail_cnt(fc3)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one sample, then return 1 time unit after the capturing edge.
    task automatic cyc(input logic [7:0] s, input logic e, input logic [1:0] m, input logic c);
        sig  = s;
        en   = e;
        mode = m;
        clr  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] exp_mf;
        logic [7:0] d3_vec [0:4];
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        mode  = 2'd0;
        sig   = 8'h00;

        #3;
        check_val("reset_outs_u1", {m1, f1, r1, s1}, 4'b0000);
        check_val("reset_outs_u3", {m3, f3, r3, s3}, 4'b0000);
        rst_n = 1'b1;

        // Warm-up, DEPTH=2
        cyc(8'h00, 1'b1, 2'd0, 1'b0);
        check_val("warm_e1", {r2, m2, f2}, 3'b000);
        cyc(8'h00, 1'b1, 2'd0, 1'b0);
        check_val("warm_e2", {r2, m2, f2}, 3'b000);
        check_val("warm_d1_ready", {r1, m1, f1}, 3'b110);
        cyc(8'h00, 1'b1, 2'd0, 1'b0);
        check_val("warm_e3", {r2, m2, f2}, 3'b110);

        // Stable then changed, DEPTH=1
        do_reset();
        cyc(8'hA5, 1'b1, 2'd0, 1'b0);
        check_val("stable_not_ready", {r1, m1, f1}, 3'b000);
        cyc(8'hA5, 1'b1, 2'd0, 1'b0);
        check_val("stable_match", {m1, f1}, 2'b10);
        cyc(8'hA4, 1'b1, 2'd0, 1'b0);
        check_val("stable_fail", {m1, f1, s1}, 3'b010);
        cyc(8'hA4, 1'b1, 2'd0, 1'b0);
        check_val("sticky_set", {m1, f1, s1}, 3'b101);

        do_reset();
        cyc(8'hA5, 1'b1, 2'd1, 1'b0);
        cyc(8'hA5, 1'b1, 2'd1, 1'b0);
        check_val("changed_fail", {m1, f1}, 2'b01);
        cyc(8'hA4, 1'b1, 2'd1, 1'b0);
        check_val("changed_match", {m1, f1}, 2'b10);

        // Rose / fell on bit 0 only
        do_reset();
        cyc(8'h02, 1'b1, 2'd2, 1'b0);
        cyc(8'h03, 1'b1, 2'd2, 1'b0);
        check_val("rose_match", {m1, f1}, 2'b10);
        do_reset();
        cyc(8'h03, 1'b1, 2'd3, 1'b0);
        cyc(8'h82, 1'b1, 2'd3, 1'b0);
        check_val("fell_match", {m1, f1}, 2'b10);
        do_reset();
        cyc(8'h02, 1'b1, 2'd2, 1'b0);
        cyc(8'h80, 1'b1, 2'd2, 1'b0);
        check_val("rose_lsb_only", {m1, f1}, 2'b01);

        // DEPTH=3 distance through an expected queue of {match, fail}
        do_reset();
        d3_vec[0] = 8'd1; d3_vec[1] = 8'd2; d3_vec[2] = 8'd3; d3_vec[3] = 8'd1; d3_vec[4] = 8'd5;
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
        for (int i = 0; i < 5; i++) begin
            cyc(d3_vec[i], 1'b1, 2'd0, 1'b0);
            exp_mf = exp_q.pop_front();
            check_val($sformatf("depth3_s%0d", i), {m3, f3}, exp_mf);
        end
        check_val("depth3_ready", r3, 1'b1);

        // clr and fail on the same edge: clr wins, next fail re-arms sticky
        do_reset();
        cyc(8'h10, 1'b1, 2'd0, 1'b0);
        cyc(8'h10, 1'b1, 2'd0, 1'b0);
        cyc(8'h11, 1'b1, 2'd0, 1'b0);
        check_val("coll_fail_pre", {f1, s1}, 2'b10);
        cyc(8'h12, 1'b1, 2'd0, 1'b1);
        check_val("coll_clr_wins", {f1, s1}, 2'b10);
        cyc(8'h13, 1'b1, 2'd0, 1'b0);
        check_val("coll_resticky", {f1, s1}, 2'b11);

        // Asynchronous reset mid-run, checked before any further edge
        rst_n = 1'b0;
        #2;
        check_val("async_rst_u1", {m1, f1, r1, s1}, 4'b0000);
        check_val("async_rst_u3", {m3, f3, r3, s3}, 4'b0000);
        rst_n = 1'b1;
        cyc(8'h07, 1'b1, 2'd0, 1'b0);
        check_val("rewarm_d1_e1", {r1, m1, f1}, 3'b000);
        cyc(8'h09, 1'b1, 2'd0, 1'b0);
        check_val("rewarm_d1_e2", {r1, m1, f1}, 3'b101);
        check_val("rewarm_d3_e2", {r3, m3, f3}, 3'b000);

        // en low keeps history running but suppresses results
        cyc(8'h09, 1'b0, 2'd1, 1'b0);
        check_val("en_low", {r1, m1, f1}, 3'b100);
        cyc(8'h09, 1'b1, 2'd0, 1'b0);
        check_val("en_back", {m1, f1}, 2'b10);

`ifdef SVC_EVENT_COUNT_EN
        // Five fails saturate a 2-bit counter at 3
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cyc(8'(i), 1'b1, 2'd0, 1'b0);
        end
        check_val("fail_cnt_sat", fc1, 2'd3);
        check_val("match_cnt_zero", mc1, 2'd0);
        cyc(8'h40, 1'b1, 2'd0, 1'b1);
        check_val("cnt_clr", fc1, 2'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
